seg_quad_accum: RTL
===================

SEG_QUAD_ACCUM -- requirements
Module: seg_quad_accum

Interface
REQ-001 SHALL have parameter NUM_WIN, default 6: number of digit windows.
REQ-002 SHALL have parameter WIN_X0, default 50: left column of window 0.
REQ-003 SHALL have parameter WIN_PITCH, default 90: column step between windows.
REQ-004 SHALL have parameter WIN_W, default 74: window width in columns.
REQ-005 SHALL have parameter WIN_Y0, default 150: top row of all windows.
REQ-006 SHALL have parameter WIN_H, default 150: window height in rows.
REQ-007 SHALL have parameter CNT_W, default 14: quadrant counter width.
REQ-008 SHALL have parameter MATCH_NIB, default 4'hA: red-nibble match value.
REQ-009 SHALL have parameter THRESH, default 100: hit threshold, CNT_W bits.
REQ-010 SHALL have port clk, input, 1: single clock, rising edge.
REQ-011 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-012 SHALL have port pix_valid, input, 1: hcnt/vcnt/pixelIn are valid this cycle.
REQ-013 SHALL have port hcnt, input, 10: pixel column.
REQ-014 SHALL have port vcnt, input, 10: pixel row.
REQ-015 SHALL have port pixelIn, input, 12: RGB444 pixel; [11:8] is red.
REQ-016 SHALL have port pixelOut, output, 12: registered pixel to the display.
REQ-017 SHALL have port quad_cnt, output, NUM_WIN*4*CNT_W: latched counts; index w*4+q, q: 0=UL, 1=UR, 2=LL, 3=LR.
REQ-018 SHALL have port quad_hit, output, NUM_WIN*4: bit set when the matching latched count >= THRESH.
REQ-019 SHALL have port frame_done, output, 1: one-cycle pulse when new results are latched.
REQ-020 SHALL have port busy, output, 1: high while in ACCUM.

Function
REQ-021 Window w SHALL span columns [WIN_X0+w*WIN_PITCH, +WIN_W) and rows [WIN_Y0, WIN_Y0+WIN_H).
REQ-022 Quadrant split SHALL be: left when col < x0+WIN_W/2, upper when row < WIN_Y0+WIN_H/2, using integer division.
REQ-023 Windows SHALL NOT overlap; an elaboration error SHALL occur if WIN_PITCH < WIN_W or the last window exceeds column 639.
REQ-024 The FSM SHALL have three states: IDLE, ACCUM, LATCH.
REQ-025 IDLE -> ACCUM on pix_valid with hcnt==0 and vcnt==0 (frame start); on that cycle all accumulators clear, then that pixel is evaluated.
REQ-026 In ACCUM, when pix_valid is high and the pixel lies in a quadrant with pixelIn[11:8]==MATCH_NIB, that quadrant's accumulator SHALL increment by 1.
REQ-027 Accumulators SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-028 ACCUM -> LATCH on pix_valid with vcnt==WIN_Y0+WIN_H and hcnt==0.
REQ-029 In LATCH (one cycle), quad_cnt and quad_hit SHALL load from the accumulators, frame_done SHALL be 1, and the FSM SHALL go to IDLE.
REQ-030 A frame start seen in ACCUM SHALL clear the accumulators and stay in ACCUM; frame_done SHALL NOT pulse and the latched outputs SHALL hold.
REQ-031 pix_valid low SHALL freeze the FSM and the accumulators.
REQ-032 quad_cnt and quad_hit SHALL hold between LATCH cycles.
REQ-033 pixelOut SHALL equal pixelIn delayed by exactly one clock, regardless of pix_valid.

Reset
REQ-034 While rst is high: FSM is IDLE; accumulators, quad_cnt, quad_hit, frame_done, busy and pixelOut are all 0.
REQ-035 Reset mid-frame SHALL discard the partial frame; after release the block waits for the next frame start.

Configuration
REQ-036 Macro SEG_OVERLAY_EN SHALL control the display overlay.
- Defined: pixelOut is 0 outside all windows. Inside windows it is pixelIn, except that a matching pixel in a quadrant whose quad_hit bit is set outputs 12'h0F0. Latency stays one clock.
- Undefined: pixelOut follows REQ-033, and no overlay logic is synthesised.

Verification
REQ-037 Reset: assert rst mid-ACCUM -> all outputs 0 that cycle; no frame_done until after a full frame following the next frame start.
REQ-038 Full 640x480 frame, 12'hA00 inside window 0 only, other pixels 12'h000 -> quad_cnt[w0] = 2775 per quadrant, quad_hit[3:0]=4'hF, others 0; frame_done one cycle after the pixel at vcnt=300, hcnt=0.
REQ-039 Frame of 12'hB00 everywhere -> all quad_cnt 0, quad_hit all 0, frame_done still pulses.
REQ-040 CNT_W=8, THRESH=8'd200, all pixels 12'hA00 -> every count 255 (saturated), every hit 1.
REQ-041 Frame start injected at vcnt=200 during ACCUM -> no frame_done; the next complete frame reports only its own counts.
REQ-042 With SEG_OVERLAY_EN, second frame as in REQ-038 -> pixelOut is 12'h0F0 inside window 0, 12'h000 outside windows, one-clock latency.

Source files
------------

// File: rtl/seg_quad_accum.sv
// Per-frame red-nibble quadrant counter over a row of digit windows, plus a one-clock registered pixel path.
// Optional display overlay (green on hit quadrants, black outside windows) enabled by defining SEG_OVERLAY_EN.
module seg_quad_accum #(
  parameter int         NUM_WIN   = 6,
  parameter int         WIN_X0    = 50,
  parameter int         WIN_PITCH = 90,
  parameter int         WIN_W     = 74,
  parameter int         WIN_Y0    = 150,
  parameter int         WIN_H     = 150,
  parameter int         CNT_W     = 14,
  parameter logic [3:0] MATCH_NIB = 4'hA,
  parameter int         THRESH    = 100
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pix_valid,
  input  logic [9:0]                   hcnt,
  input  logic [9:0]                   vcnt,
  input  logic [11:0]                  pixelIn,
  output logic [11:0]                  pixelOut,
  output logic [NUM_WIN*4*CNT_W-1:0]   quad_cnt,
  output logic [NUM_WIN*4-1:0]         quad_hit,
  output logic                         frame_done,
  output logic                         busy
);

  localparam int NQ     = NUM_WIN * 4;
  localparam int HALF_W = WIN_W / 2;
  localparam int Y_MID  = WIN_Y0 + WIN_H / 2;
  localparam int Y_END  = WIN_Y0 + WIN_H;
  localparam int X_LAST = WIN_X0 + (NUM_WIN - 1) * WIN_PITCH + WIN_W - 1;
  localparam logic [CNT_W-1:0] THR     = CNT_W'(THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (WIN_PITCH < WIN_W) begin : g_bad_pitch
    $error("seg_quad_accum: WIN_PITCH %0d is smaller than WIN_W %0d", WIN_PITCH, WIN_W);
  end
  if (X_LAST > 639) begin : g_bad_span
    $error("seg_quad_accum: last window column %0d exceeds 639", X_LAST);
  end

  typedef enum logic [1:0] {IDLE, ACCUM, LATCH} state_t;

  state_t           state;
  logic [CNT_W-1:0] acc [NQ];
  logic [NQ-1:0]    in_quad;
  logic [NQ-1:0]    cnt_en;
  logic [11:0]      pix_p0;
  logic             match, frame_start, frame_end, eval, clr;
  int               col, row;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // Stage 0: classify the incoming pixel against every window quadrant
  assign col         = int'(hcnt);
  assign row         = int'(vcnt);
  assign match       = (pixelIn[11:8] == MATCH_NIB);
  assign frame_start = (hcnt == 10'd0) && (vcnt == 10'd0);
  assign frame_end   = (hcnt == 10'd0) && (vcnt == 10'(Y_END));

  always_comb begin
    logic in_w, rt, lo;
    in_w    = 1'b0;
    rt      = 1'b0;
    lo      = 1'b0;
    in_quad = '0;
    for (int w = 0; w < NUM_WIN; w++) begin
      in_w = (col >= WIN_X0 + w * WIN_PITCH) && (col < WIN_X0 + w * WIN_PITCH + WIN_W) &&
             (row >= WIN_Y0) && (row < Y_END);
      rt   = (col >= WIN_X0 + w * WIN_PITCH + HALF_W);
      lo   = (row >= Y_MID);
      in_quad[w*4+0] = in_w & ~rt & ~lo;
      in_quad[w*4+1] = in_w &  rt & ~lo;
      in_quad[w*4+2] = in_w & ~rt &  lo;
      in_quad[w*4+3] = in_w &  rt &  lo;
    end
  end

  // A frame start both clears the accumulators and counts its own pixel
  assign eval   = pix_valid && ((state == ACCUM) || ((state == IDLE) && frame_start));
  assign clr    = pix_valid && frame_start && (state != LATCH);
  assign cnt_en = in_quad & {NQ{eval && match}};

`ifdef SEG_OVERLAY_EN
  always_comb begin
    pix_p0 = 12'h000;
    if (|in_quad)
      pix_p0 = (match && |(in_quad & quad_hit)) ? 12'h0F0 : pixelIn;
  end
`else
  assign pix_p0 = pixelIn;
`endif

  // Stage 1: registered pixel, FSM, accumulators and latched results
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pixelOut <= 12'h000;
    end else begin
      pixelOut <= pix_p0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      frame_done <= 1'b0;
      quad_cnt   <= '0;
      quad_hit   <= '0;
      for (int i = 0; i < NQ; i++) acc[i] <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (pix_valid && frame_start) begin
            state <= ACCUM;
            busy  <= 1'b1;
          end
        end
        ACCUM: begin
          if (pix_valid && frame_end) begin
            state      <= LATCH;
            busy       <= 1'b0;
            frame_done <= 1'b1;
            for (int i = 0; i < NQ; i++) begin
              quad_cnt[i*CNT_W +: CNT_W] <= acc[i];
              quad_hit[i]                <= (acc[i] >= THR);
            end
          end
        end
        default: state <= IDLE;
      endcase
      for (int i = 0; i < NQ; i++) begin
        if (clr)
          acc[i] <= {{(CNT_W-1){1'b0}}, cnt_en[i]};
        else if (cnt_en[i])
          acc[i] <= sat_inc(acc[i]);
      end
    end
  end

endmodule
